// File: rtl/regfile_if.sv
// Register-file port bundle: one write-back port from MEM/WB and two ID-stage read ports.
// The master side drives requests; the regfile (slave) returns combinational read data.
interface regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              w_enable;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    logic              r1_enable;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_data;

    logic              r2_enable;
    logic [ADDR_W-1:0] r2_addr;
    logic [DATA_W-1:0] r2_data;

    modport master (
        output w_enable, w_addr, w_data,
        output r1_enable, r1_addr,
        output r2_enable, r2_addr,
        input  r1_data, r2_data
    );

    modport slave (
        input  w_enable, w_addr, w_data,
        input  r1_enable, r1_addr,
        input  r2_enable, r2_addr,
        output r1_data, r2_data
    );
endinterface

// File: rtl/regfile.sv
// RV32I integer register file: 32 x 32-bit, x0 hardwired to zero, two combinational
// read ports with same-cycle write-to-read bypass, writes gated by the global rdy.
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    regfile_if.slave bus
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (rdy && bus.w_enable && (bus.w_addr != '0)) begin
            regs[bus.w_addr] <= bus.w_data;
        end
    end

    // Bypass deliberately ignores rdy: ID sees the write-port inputs even while storage is frozen.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              reset,
        input logic              enable,
        input logic [ADDR_W-1:0] addr,
        input logic              wen,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] value;
        value = '0;
        if (!reset && enable && (addr != '0)) begin
            if (wen && (waddr == addr)) begin
                value = wdata;
            end else begin
                value = stored;
            end
        end
        return value;
    endfunction

    always_comb begin
        bus.r1_data = '0;
        bus.r1_data = read_port(rst, bus.r1_enable, bus.r1_addr,
                                bus.w_enable, bus.w_addr, bus.w_data,
                                regs[bus.r1_addr]);
    end

    always_comb begin
        bus.r2_data = '0;
        bus.r2_data = read_port(rst, bus.r2_enable, bus.r2_addr,
                                bus.w_enable, bus.w_addr, bus.w_data,
                                regs[bus.r2_addr]);
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: each stimulus cycle queues hand-computed read-port values,
// and an independent monitor compares them against the DUT at the falling edge.
module tb_regfile;

    logic clk;
    logic rst;
    logic rdy;

    regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t q[$];
    int   n_compared = 0;
    int   n_mismatched = 0;
    bit   stim_done = 1'b0;

    // Monitor: read data is valid mid-cycle, so every queued expectation is checked at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_compared++;
                if (bus.r1_data !== e.e1) begin
                    n_mismatched++;
                    $display("FAIL %s r1_data: got %08h expected %08h", e.name, bus.r1_data, e.e1);
                end
                n_compared++;
                if (bus.r2_data !== e.e2) begin
                    n_mismatched++;
                    $display("FAIL %s r2_data: got %08h expected %08h", e.name, bus.r2_data, e.e2);
                end
            end
        end
    end

    task automatic step(
        input string       name,
        input logic        r,
        input logic        rd,
        input logic        we,
        input logic [4:0]  wa,
        input logic [31:0] wd,
        input logic        en1,
        input logic [4:0]  a1,
        input logic        en2,
        input logic [4:0]  a2,
        input logic [31:0] x1,
        input logic [31:0] x2
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        rdy           = rd;
        bus.w_enable  = we;
        bus.w_addr    = wa;
        bus.w_data    = wd;
        bus.r1_enable = en1;
        bus.r1_addr   = a1;
        bus.r2_enable = en2;
        bus.r2_addr   = a2;
        e.name = name;
        e.e1   = x1;
        e.e2   = x2;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.w_enable  = 1'b0;
        bus.w_addr    = '0;
        bus.w_data    = '0;
        bus.r1_enable = 1'b0;
        bus.r1_addr   = '0;
        bus.r2_enable = 1'b0;
        bus.r2_addr   = '0;

        //    name            rst   rdy  we  wa     wd            en1 a1     en2 a2     exp1          exp2
        step("reset_state",   1'b1, 1, 0, 5'd0,  32'h0,        1, 5'd5,  1, 5'd5,  32'h0,        32'h0);
        step("wr_x5_bypass",  1'b0, 1, 1, 5'd5,  32'hDEADBEEF, 1, 5'd5,  1, 5'd6,  32'hDEADBEEF, 32'h0);
        step("rd_x5_stored",  1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd5,  1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF);
        step("rst_mid_cycle", 1'b1, 1, 0, 5'd0,  32'h0,        1, 5'd5,  1, 5'd5,  32'h0,        32'h0);
        step("x5_after_rst",  1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd5,  1, 5'd5,  32'h0,        32'h0);
        step("wr_x7",         1'b0, 1, 1, 5'd7,  32'h12345678, 1, 5'd7,  1, 5'd8,  32'h12345678, 32'h0);
        step("rd_x7_both",    1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd7,  1, 5'd7,  32'h12345678, 32'h12345678);
        step("rd_x8_x7",      1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd8,  1, 5'd7,  32'h0,        32'h12345678);
        step("wr_x0_cycle",   1'b0, 1, 1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  1, 5'd0,  32'h0,        32'h0);
        step("rd_x0_after",   1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd0,  1, 5'd0,  32'h0,        32'h0);
        step("wr_x3_one",     1'b0, 1, 1, 5'd3,  32'h00000001, 1, 5'd3,  1, 5'd4,  32'h00000001, 32'h0);
        step("wr_x4",         1'b0, 1, 1, 5'd4,  32'h0F0F0F0F, 1, 5'd3,  1, 5'd4,  32'h00000001, 32'h0F0F0F0F);
        step("bypass_x3",     1'b0, 1, 1, 5'd3,  32'hAAAA5555, 1, 5'd4,  1, 5'd3,  32'h0F0F0F0F, 32'hAAAA5555);
        step("x3_x4_stored",  1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd3,  1, 5'd4,  32'hAAAA5555, 32'h0F0F0F0F);
        step("rdy0_bypass",   1'b0, 0, 1, 5'd9,  32'hCAFEF00D, 1, 5'd9,  1, 5'd9,  32'hCAFEF00D, 32'hCAFEF00D);
        step("rdy0_no_store", 1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd9,  1, 5'd9,  32'h0,        32'h0);
        step("rdy1_wr_x9",    1'b0, 1, 1, 5'd9,  32'hCAFEF00D, 1, 5'd9,  1, 5'd7,  32'hCAFEF00D, 32'h12345678);
        step("rdy1_stored",   1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd9,  1, 5'd9,  32'hCAFEF00D, 32'hCAFEF00D);
        step("r1_disabled",   1'b0, 1, 0, 5'd0,  32'h0,        0, 5'd7,  1, 5'd7,  32'h0,        32'h12345678);
        step("r2_disabled",   1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd7,  0, 5'd7,  32'h12345678, 32'h0);
        step("b2b_first",     1'b0, 1, 1, 5'd10, 32'h11111111, 1, 5'd10, 1, 5'd10, 32'h11111111, 32'h11111111);
        step("b2b_second",    1'b0, 1, 1, 5'd10, 32'h22222222, 1, 5'd10, 1, 5'd10, 32'h22222222, 32'h22222222);
        step("b2b_last_wins", 1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd10, 1, 5'd10, 32'h22222222, 32'h22222222);
        step("dis_over_byp",  1'b0, 0, 1, 5'd9,  32'h55555555, 0, 5'd9,  1, 5'd9,  32'h0,        32'h55555555);
        step("x9_kept",       1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd9,  1, 5'd10, 32'hCAFEF00D, 32'h22222222);
        step("wr_x31_full",   1'b0, 1, 1, 5'd31, 32'h80000001, 1, 5'd31, 1, 5'd30, 32'h80000001, 32'h0);
        step("x31_stored",    1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd31, 1, 5'd31, 32'h80000001, 32'h80000001);
        step("rst_vs_write",  1'b1, 1, 1, 5'd11, 32'h77777777, 1, 5'd11, 1, 5'd11, 32'h0,        32'h0);
        step("x11_lost",      1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd11, 1, 5'd3,  32'h0,        32'h0);
        step("x31_cleared",   1'b0, 1, 0, 5'd0,  32'h0,        1, 5'd31, 1, 5'd7,  32'h0,        32'h0);

        @(posedge clk);
        @(posedge clk);
        stim_done = 1'b1;
        n_compared++;
        if (q.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #5000;
        if (!stim_done) begin
            $display("FAIL timeout: got no completion by 5000, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
